// File: rtl/net_pkg.sv
`default_nettype none
// ============================================================================
// Module      : net_pkg
// Description : Shared types and constants for the network stream blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package net_pkg;

    localparam int NET_DATA_W            = 64;
    localparam int NET_MAX_BEATS_DEFAULT = 190;

    typedef enum logic [0:0] {
        NET_ARB_IDLE = 1'b0,
        NET_ARB_BUSY = 1'b1
    } net_arb_state_t;

    // Width of a stream index; a single stream still needs one bit.
    function automatic int net_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/net_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : net_stream_arbiter_if
// Description : N input streams plus one merged output stream and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface net_stream_arbiter_if
    import net_pkg::*;
#(
    parameter int N_IN = 4
) ();

    localparam int IDX_W = net_idx_w(N_IN);

    logic [N_IN-1:0]            in_valid;
    logic [N_IN-1:0]            in_ready;
    logic [NET_DATA_W*N_IN-1:0] in_bits_data;
    logic [N_IN-1:0]            in_bits_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [NET_DATA_W-1:0]      out_bits_data;
    logic                       out_bits_last;
    logic [IDX_W-1:0]           out_chosen;
    logic [31:0]                pkt_count;
    logic                       err_overlong;

    modport master (
        output in_valid, in_bits_data, in_bits_last, out_ready,
        input  in_ready, out_valid, out_bits_data, out_bits_last,
               out_chosen, pkt_count, err_overlong
    );

    modport slave (
        input  in_valid, in_bits_data, in_bits_last, out_ready,
        output in_ready, out_valid, out_bits_data, out_bits_last,
               out_chosen, pkt_count, err_overlong
    );

endinterface
`default_nettype wire

// File: rtl/net_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : net_rr_picker
// Description : Combinational round-robin pick: first valid after rr_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module net_rr_picker
    import net_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic [N_IN-1:0]            valid,
    input  logic [net_idx_w(N_IN)-1:0] rr_ptr,
    output logic [net_idx_w(N_IN)-1:0] sel,
    output logic                       any_valid
);

    localparam int IDX_W = net_idx_w(N_IN);

    // Scan from farthest to nearest so the nearest valid stream wins.
    always_comb begin
        sel       = IDX_W'((int'(rr_ptr) + 1) % N_IN);
        any_valid = |valid;
        for (int k = N_IN; k >= 1; k--) begin
            if (valid[(int'(rr_ptr) + k) % N_IN]) begin
                sel = IDX_W'((int'(rr_ptr) + k) % N_IN);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/net_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : net_stream_arbiter
// Description : Packet-level round-robin merge of N streams onto one output.
// Revision    : 1.0 - initial release
// ============================================================================
module net_stream_arbiter
    import net_pkg::*;
#(
    parameter int N_IN      = 4,
    parameter int MAX_BEATS = NET_MAX_BEATS_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    net_stream_arbiter_if.slave bus
);

    localparam int IDX_W = net_idx_w(N_IN);
    localparam int CNT_W = $clog2(MAX_BEATS + 2);
    localparam logic [CNT_W-1:0] c_max_beats = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] c_beat_sat  = CNT_W'(MAX_BEATS + 1);

    net_arb_state_t   r_state,     w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr,    w_rr_ptr_nxt;
    logic [IDX_W-1:0] r_lock_idx,  w_lock_idx_nxt;
    logic [CNT_W-1:0] r_beat_cnt,  w_beat_cnt_nxt;
    logic [31:0]      r_pkt_count, w_pkt_count_nxt;
    logic             r_err,       w_err_nxt;

    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_sel;
    logic             w_any_valid;
    logic             w_out_valid;
    logic             w_last;
    logic             w_fire;
    logic [N_IN-1:0]  w_in_ready;

    net_rr_picker #(
        .N_IN (N_IN)
    ) u_picker (
        .valid     (bus.in_valid),
        .rr_ptr    (r_rr_ptr),
        .sel       (w_pick),
        .any_valid (w_any_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= NET_ARB_IDLE;
            r_rr_ptr    <= IDX_W'(N_IN - 1);
            r_lock_idx  <= '0;
            r_beat_cnt  <= '0;
            r_pkt_count <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_lock_idx  <= w_lock_idx_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_pkt_count <= w_pkt_count_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_lock_idx_nxt  = r_lock_idx;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_pkt_count_nxt = r_pkt_count;
        w_err_nxt       = r_err;

        // The picker only produces a valid-less index when nothing is valid.
        w_sel       = (r_state == NET_ARB_BUSY) ? r_lock_idx : w_pick;
        w_out_valid = !reset && ((r_state == NET_ARB_BUSY) ? bus.in_valid[w_sel]
                                                           : w_any_valid);
        w_last      = bus.in_bits_last[w_sel];
        w_fire      = w_out_valid && bus.out_ready;

        w_in_ready = '0;
        if (!reset && bus.out_ready) begin
            w_in_ready[w_sel] = 1'b1;
        end

        case (r_state)
            NET_ARB_IDLE: begin
                if (w_fire) begin
                    if (w_last) begin
                        w_rr_ptr_nxt    = w_sel;
                        w_pkt_count_nxt = r_pkt_count + 32'd1;
                    end else begin
                        w_state_nxt    = NET_ARB_BUSY;
                        w_lock_idx_nxt = w_sel;
                        w_beat_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            NET_ARB_BUSY: begin
                if (w_fire) begin
                    // This transfer is beat r_beat_cnt+1 of the packet.
                    if (r_beat_cnt >= c_max_beats) begin
                        w_err_nxt = 1'b1;
                    end
                    if (w_last) begin
                        w_state_nxt     = NET_ARB_IDLE;
                        w_rr_ptr_nxt    = r_lock_idx;
                        w_pkt_count_nxt = r_pkt_count + 32'd1;
                        w_beat_cnt_nxt  = '0;
                    end else if (r_beat_cnt < c_beat_sat) begin
                        w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = NET_ARB_IDLE;
            end
        endcase
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = w_out_valid;
    assign bus.out_bits_data = bus.in_bits_data[NET_DATA_W*w_sel +: NET_DATA_W];
    assign bus.out_bits_last = w_last;
    assign bus.out_chosen    = w_sel;
    assign bus.pkt_count     = r_pkt_count;
    assign bus.err_overlong  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_net_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_net_stream_arbiter
// Description : Directed vector bench for net_stream_arbiter (N_IN=4, MAX_BEATS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_net_stream_arbiter;
    import net_pkg::*;

    localparam int N_IN = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    net_stream_arbiter_if #(.N_IN(N_IN)) bus ();

    net_stream_arbiter #(
        .N_IN      (N_IN),
        .MAX_BEATS (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] dat;    // one byte per stream, {s3,s2,s1,s0}
        logic        ordy;
        logic        ov;
        logic [7:0]  odat;
        logic        olast;
        logic [1:0]  ch;
        logic [3:0]  ir;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] valid,
                                input logic [3:0] last, input logic [31:0] dat,
                                input logic ordy, input logic ov,
                                input logic [7:0] odat, input logic olast,
                                input logic [1:0] ch, input logic [3:0] ir,
                                input logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.valid = valid; v.last = last; v.dat = dat; v.ordy = ordy;
        v.ov = ov; v.odat = odat; v.olast = olast; v.ch = ch; v.ir = ir; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] valid, input logic [3:0] last,
                         input logic [31:0] dat, input logic ordy);
        reset            = rst;
        bus.in_valid     = valid;
        bus.in_bits_last = last;
        bus.out_ready    = ordy;
        for (int i = 0; i < N_IN; i++) begin
            bus.in_bits_data[64*i +: 64] = {56'h0, dat[8*i +: 8]};
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b;
        int cyc;
        logic ordy;

        drive(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b1);
        tick();
        tick();

        // Streams 0 and 2 each offer a 3-beat packet in the same cycle.
        vecs.push_back(mk(1, 4'b0101, 4'b0000, 32'h00C0_00A0, 1, 0, 8'h00, 0, 2'd0, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0101, 4'b0000, 32'h00C0_00A0, 1, 1, 8'hA0, 0, 2'd0, 4'b0001, 0));
        vecs.push_back(mk(0, 4'b0101, 4'b0000, 32'h00C0_00A1, 1, 1, 8'hA1, 0, 2'd0, 4'b0001, 0));
        vecs.push_back(mk(0, 4'b0101, 4'b0001, 32'h00C0_00A2, 1, 1, 8'hA2, 1, 2'd0, 4'b0001, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 32'h00C0_0000, 1, 1, 8'hC0, 0, 2'd2, 4'b0100, 1));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 32'h00C1_0000, 1, 1, 8'hC1, 0, 2'd2, 4'b0100, 1));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 32'h00C2_0000, 1, 1, 8'hC2, 1, 2'd2, 4'b0100, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 0, 2'd3, 4'b1000, 2));
        // Reset, then all four streams offer single-beat packets continuously.
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 0, 2'd0, 4'b0000, 0));
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(0, 4'b1111, 4'b1111, 32'h1312_1110, 1, 1, 8'(8'h10 + (k % 4)), 1,
                              2'(k % 4), 4'(1 << (k % 4)), 32'(k)));
        end
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 0, 2'd0, 4'b0001, 8));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].last, vecs[i].dat, vecs[i].ordy);
            check($sformatf("v%0d out_valid", i), 64'(bus.out_valid), 64'(vecs[i].ov));
            check($sformatf("v%0d in_ready", i), 64'(bus.in_ready), 64'(vecs[i].ir));
            if (!vecs[i].rst) begin
                check($sformatf("v%0d out_data", i), bus.out_bits_data, 64'(vecs[i].odat));
                check($sformatf("v%0d out_last", i), 64'(bus.out_bits_last), 64'(vecs[i].olast));
                check($sformatf("v%0d out_chosen", i), 64'(bus.out_chosen), 64'(vecs[i].ch));
                check($sformatf("v%0d pkt_count", i), 64'(bus.pkt_count), 64'(vecs[i].cnt));
            end
            tick();
        end

        // Locked stream 1 stalls for 5 cycles while stream 3 waits.
        drive(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b1);
        tick();
        drive(1'b0, 4'b1010, 4'b1000, 32'hD000_B000, 1'b1);
        check("stall first chosen", 64'(bus.out_chosen), 64'd1);
        check("stall first data", bus.out_bits_data, 64'hB0);
        check("stall first in_ready", 64'(bus.in_ready), 64'b0010);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 4'b1000, 4'b1000, 32'hD000_0000, 1'b1);
            check($sformatf("stall%0d out_valid", k), 64'(bus.out_valid), 64'd0);
            check($sformatf("stall%0d in_ready3", k), 64'(bus.in_ready[3]), 64'd0);
            check($sformatf("stall%0d chosen", k), 64'(bus.out_chosen), 64'd1);
            tick();
        end
        drive(1'b0, 4'b1010, 4'b1010, 32'hD000_B100, 1'b1);
        check("stall resume valid", 64'(bus.out_valid), 64'd1);
        check("stall resume data", bus.out_bits_data, 64'hB1);
        check("stall resume last", 64'(bus.out_bits_last), 64'd1);
        tick();
        drive(1'b0, 4'b1000, 4'b1000, 32'hD000_0000, 1'b1);
        check("stall then s3 chosen", 64'(bus.out_chosen), 64'd3);
        check("stall then s3 data", bus.out_bits_data, 64'hD0);
        check("stall then s3 in_ready", 64'(bus.in_ready), 64'b1000);
        check("stall count1", 64'(bus.pkt_count), 64'd1);
        tick();
        drive(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);
        check("stall count2", 64'(bus.pkt_count), 64'd2);

        // 4-beat packet from stream 2 with out_ready toggling 1,0,1,0.
        drive(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b1);
        tick();
        b = 0;
        cyc = 0;
        while (b < 4 && cyc < 20) begin
            ordy = (cyc % 2 == 0);
            drive(1'b0, 4'b0100, (b == 3) ? 4'b0100 : 4'b0000,
                  {8'h00, 8'(8'hE0 + b), 16'h0000}, ordy);
            check($sformatf("toggle c%0d data", cyc), bus.out_bits_data, 64'(8'hE0 + b));
            check($sformatf("toggle c%0d chosen", cyc), 64'(bus.out_chosen), 64'd2);
            check($sformatf("toggle c%0d in_ready2", cyc), 64'(bus.in_ready[2]), 64'(ordy));
            if (ordy) b++;
            cyc++;
            tick();
        end
        check("toggle cycles used", 64'(cyc), 64'd7);
        drive(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);
        check("toggle count", 64'(bus.pkt_count), 64'd1);
        check("toggle 4 beats not overlong", 64'(bus.err_overlong), 64'd0);

        // 5-beat packet from stream 0 exceeds MAX_BEATS=4.
        drive(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 4'b0001, (k == 4) ? 4'b0001 : 4'b0000, 32'(8'hF0 + k), 1'b1);
            check($sformatf("overlong b%0d data", k), bus.out_bits_data, 64'(8'hF0 + k));
            check($sformatf("overlong b%0d valid", k), 64'(bus.out_valid), 64'd1);
            check($sformatf("overlong b%0d err", k), 64'(bus.err_overlong), 64'd0);
            tick();
        end
        drive(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);
        check("overlong err rises", 64'(bus.err_overlong), 64'd1);
        tick();
        tick();
        check("overlong err sticky", 64'(bus.err_overlong), 64'd1);
        check("overlong count", 64'(bus.pkt_count), 64'd1);

        // Reset in the middle of a 4-beat packet from stream 3.
        drive(1'b0, 4'b1000, 4'b0000, 32'h3000_0000, 1'b1);
        check("midrst s3 chosen", 64'(bus.out_chosen), 64'd3);
        tick();
        drive(1'b0, 4'b1000, 4'b0000, 32'h3100_0000, 1'b1);
        check("midrst s3 beat2", bus.out_bits_data, 64'h31);
        tick();
        drive(1'b1, 4'b1001, 4'b0000, 32'h3200_0030, 1'b1);
        check("midrst out_valid in reset", 64'(bus.out_valid), 64'd0);
        check("midrst in_ready in reset", 64'(bus.in_ready), 64'd0);
        tick();
        drive(1'b0, 4'b1001, 4'b0000, 32'h3200_0030, 1'b1);
        check("midrst s0 chosen", 64'(bus.out_chosen), 64'd0);
        check("midrst s0 data", bus.out_bits_data, 64'h30);
        check("midrst count", 64'(bus.pkt_count), 64'd0);
        check("midrst err", 64'(bus.err_overlong), 64'd0);
        tick();
        drive(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/net_stream_arbiter.md
Name: net_stream_arbiter

Overview:
- Packet-level round-robin arbiter that merges N NIC egress streams onto the single net_out stream of the simulated network device.
- Each stream carries 64-bit beats with a last flag.
- Once a packet starts, the grant is held until its last beat is accepted, so packets are never interleaved.
- Also tracks completed-packet count and flags overlong packets for the bench and software.

Parameters:
- N_IN, 4, number of requesting streams (1..16)
- MAX_BEATS, 190, legal maximum beats per packet (1514-byte frame rounded up to 64-bit words); longer packets set err_overlong
- IDX_W, max(1,$clog2(N_IN)), width of grant index (derived, not overridable)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- in_valid  in  N_IN  per-stream beat valid
- in_ready  out  N_IN  per-stream beat ready
- in_bits_data  in  64*N_IN  stream i at bits [64*i+63:64*i]
- in_bits_last  in  N_IN  per-stream last-beat flag
- out_valid  out  1  merged beat valid
- out_ready  in  1  downstream ready
- out_bits_data  out  64  merged beat data
- out_bits_last  out  1  merged last flag
- out_chosen  out  IDX_W  index of stream currently driving out
- pkt_count  out  32  packets completed since reset
- err_overlong  out  1  sticky overlong-packet flag

Behaviour:
- Interface: single clock `clock`; `reset` is synchronous and active-high.
- Reset values (held while reset asserted, including mid-packet):
  - state=IDLE, rr_ptr=N_IN-1 (stream 0 has highest priority first), beat_cnt=0, pkt_count=0, err_overlong=0.
  - out_valid=0 and in_ready=0 during reset.
  - A packet in flight at reset is abandoned; no recovery is attempted.
- Datapath:
  - Zero-latency combinational mux from selected stream `sel` to out_*.
  - out_valid = in_valid[sel] (IDLE: any valid exists).
  - in_ready[i] = out_ready && (i==sel); all others 0.
  - Transfer = out_valid && out_ready.
- State machine, IDLE:
  - sel = first i with in_valid[i], scanning rr_ptr+1, rr_ptr+2, … modulo N_IN.
  - With no valid input, sel=rr_ptr+1 mod N_IN and out_valid=0.
  - Transfer with last=0 → BUSY, lock_idx<=sel, beat_cnt<=1.
  - Transfer with last=1 (single-beat packet) → stay IDLE, rr_ptr<=sel, pkt_count++.
- State machine, BUSY:
  - sel=lock_idx regardless of other valids.
  - in_valid[lock_idx] dropping mid-packet: out_valid=0, remain BUSY, no starvation switch.
  - Transfer with last=0 → beat_cnt++ (saturating at MAX_BEATS+1).
  - Transfer with last=1 → IDLE, rr_ptr<=lock_idx, pkt_count++, beat_cnt<=0.
- out_chosen = sel in both states.
- Overlong detection:
  - err_overlong<=1 on any transfer whose beat number within the packet (1-based) exceeds MAX_BEATS.
  - Sticky until reset. The packet is still forwarded unchanged.
- pkt_count wraps 2^32-1 → 0.
- Fairness: after a packet from stream k, every other valid stream is served before k again.
- N_IN=1: degenerates to passthrough with lock/count/error logic intact; out_chosen=0.
- out_ready low: state, counters and rr_ptr hold.

Decomposition:
- Shared package net_pkg:
  - NET_DATA_W=64
  - NET_MAX_BEATS_DEFAULT=190
  - state enum {NET_ARB_IDLE, NET_ARB_BUSY}
- Sub-module net_rr_picker (combinational): inputs valid vector and rr_ptr; outputs sel index and any_valid. Reusable by future ingress demux/scheduler.

Test Plan:
- N_IN=4; reset, then streams 0 and 2 each present one 3-beat packet (data 0xA0..A2, 0xC0..C2) in the same cycle → out carries A0,A1,A2(last), then C0,C1,C2(last), no interleave; out_chosen 0 then 2; pkt_count=2.
- All 4 streams continuously offer 1-beat packets, out_ready=1 → grant sequence 0,1,2,3,0,1… one per cycle; pkt_count=8 after 8 cycles.
- Stream 1 sends beat 1 of a 2-beat packet, then deasserts valid 5 cycles while stream 3 is valid → out_valid=0, in_ready[3]=0 throughout; stream 1 resumes → beat 2 forwarded, then stream 3 granted.
- out_ready toggles 1,0,1,0 during a 4-beat packet from stream 2 → each beat transferred exactly once, in order, out_bits held stable while out_ready=0.
- MAX_BEATS=4; stream 0 sends a 5-beat packet → err_overlong rises in the cycle after beat 5 transfers and stays 1; all 5 beats forwarded; pkt_count=1.
- Assert reset for 1 cycle after beat 2 of a 4-beat packet from stream 3 → out_valid=0 during reset; afterwards stream 0 (valid) is granted first, pkt_count=0, err_overlong=0.
